// File: rtl/grn_node_array.sv
`default_nettype none
// ============================================================================
// Module   : grn_node_array
// Brief    : Bank of N GRN state channels with per-channel update periods,
//            change pulses and a saturating steady-state counter.
// Revision : 1.0 - initial release
// ============================================================================
module grn_node_array #(
    parameter int N         = 2,
    parameter int W         = 1,
    parameter int PW        = 4,
    parameter int SW        = 8,
    parameter int STABLE_TH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               reset_nos,
    input  logic [N*W-1:0]                     init_state,
    input  logic [N-1:0]                       start_s,
    input  logic [N*W-1:0]                     stat_s,
    input  logic                               cfg_we,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] cfg_idx,
    input  logic [PW-1:0]                      cfg_period,
    output logic [N*W-1:0]                     s,
    output logic [N*W-1:0]                     erm_s,
    output logic [N-1:0]                       changed,
    output logic [SW-1:0]                      stable_cnt,
    output logic                               stable
);

    localparam int            c_IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] c_SMAX = {SW{1'b1}};

    logic [W-1:0]  r_s   [N];
    logic [PW-1:0] r_per [N];
    logic [PW-1:0] r_ph  [N];
    logic          r_chg [N];
    logic [SW-1:0] r_cnt;
    logic [N-1:0]  w_chg;
    logic          w_step;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic w_upd;
        logic w_cfg_hit;

        assign w_upd     = start_s[i] && (r_ph[i] == r_per[i]);
        assign w_cfg_hit = cfg_we && (cfg_idx == c_IW'(i));
        assign w_chg[i]  = w_upd && (stat_s[i*W +: W] != r_s[i]);

        // The cfg write lands after the update decision, so it overrides ph.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s[i]   <= '0;
                r_per[i] <= '0;
                r_ph[i]  <= '0;
                r_chg[i] <= 1'b0;
            end else if (reset_nos) begin
                r_s[i]   <= init_state[i*W +: W];
                r_ph[i]  <= r_per[i];
                r_chg[i] <= 1'b0;
            end else begin
                r_chg[i] <= w_chg[i];
                if (w_upd) begin
                    r_s[i]  <= stat_s[i*W +: W];
                    r_ph[i] <= '0;
                end else if (start_s[i]) begin
                    r_ph[i] <= r_ph[i] + PW'(1);
                end
                if (w_cfg_hit) begin
                    r_per[i] <= cfg_period;
                    r_ph[i]  <= cfg_period;
                end
            end
        end

        assign s[i*W +: W] = r_s[i];
        assign changed[i]  = r_chg[i];
    end

    assign w_step = !reset_nos && (|start_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (reset_nos) begin
            r_cnt <= '0;
        end else if (w_step) begin
            if (|w_chg)
                r_cnt <= '0;
            else if (r_cnt != c_SMAX)
                r_cnt <= r_cnt + SW'(1);
        end
    end

    assign erm_s      = s;
    assign stable_cnt = r_cnt;
    assign stable     = (r_cnt >= SW'(STABLE_TH));

endmodule
`default_nettype wire
